// File: rtl/proj_select_pkg.sv
// proj_select_pkg: shared state encoding and sizing helpers for the project selector
package proj_select_pkg;
  typedef enum logic [1:0] {OFF, DEAD, ON} state_t;
  localparam int MAX_DEAD = 255;
  function automatic int sel_w(input int n);
    return n <= 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/proj_dead_timer.sv
// proj_dead_timer: 8-bit loadable down-counter; busy while nonzero, done while on its last count (clk, rst_n, load, load_val -> busy, done)
module proj_dead_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       busy,
  output logic       done
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != 8'd0 ? cnt_q - 8'd1 : cnt_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  assign busy = cnt_q != 8'd0;
  assign done = cnt_q == 8'd1;
endmodule

// File: rtl/proj_select_ctrl.sv
// proj_select_ctrl: break-before-make selector driving zero-or-one-hot active_o with a dead time on every hand-over (req_* handshake in; active_o, cur_idx_o, cur_valid_o, busy_o, err_o out; checks under PROJ_SELECT_ONEHOT_ASSERT_EN)
module proj_select_ctrl
  import proj_select_pkg::*;
#(
  parameter int N_PROJ      = 2,
  parameter int SEL_W       = sel_w(N_PROJ),
  parameter int DEAD_CYCLES = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [SEL_W-1:0]  req_idx_i,
  input  logic              req_off_i,
  output logic [N_PROJ-1:0] active_o,
  output logic [SEL_W-1:0]  cur_idx_o,
  output logic              cur_valid_o,
  output logic              busy_o,
  output logic              err_o
);
  state_t state_q, state_d;
  logic [SEL_W-1:0] pend_idx_q, pend_idx_d, cur_idx_q, cur_idx_d;
  logic [N_PROJ-1:0] active_q, active_d;
  logic pend_on_q, pend_on_d, err_q, err_d;
  logic hs, idx_ok, load, t_busy, t_done;
  assign req_ready_o = state_q != DEAD;
  assign hs          = req_valid_i && req_ready_o;
  assign idx_ok      = 32'(req_idx_i) < N_PROJ;
  proj_dead_timer u_timer (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n_i),
    .load     (load),
    .load_val (8'(DEAD_CYCLES)),
    .busy     (t_busy),
    .done     (t_done)
  );
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      state_q    <= OFF;
      pend_idx_q <= '0;
      pend_on_q  <= 1'b0;
      cur_idx_q  <= '0;
      active_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_idx_q <= pend_idx_d;
      pend_on_q  <= pend_on_d;
      cur_idx_q  <= cur_idx_d;
      active_q   <= active_d;
      err_q      <= err_d;
    end
  // pend_on_q distinguishes a hand-over (finish in ON) from an off request (finish in OFF)
  always_comb begin
    state_d    = state_q;
    pend_idx_d = pend_idx_q;
    pend_on_d  = pend_on_q;
    load       = 1'b0;
    err_d      = hs && !req_off_i && !idx_ok;
    if (hs && req_off_i && state_q == ON) begin
      state_d   = DEAD;
      pend_on_d = 1'b0;
      load      = 1'b1;
    end else if (hs && !req_off_i && idx_ok && (state_q == OFF || req_idx_i != cur_idx_q)) begin
      state_d    = DEAD;
      pend_on_d  = 1'b1;
      pend_idx_d = req_idx_i;
      load       = 1'b1;
    end
    if (state_q == DEAD && t_done) state_d = pend_on_q ? ON : OFF;
  end
  always_comb begin
    cur_idx_d = (state_q == DEAD && t_done && pend_on_q) ? pend_idx_q : cur_idx_q;
    active_d  = state_d == ON ? N_PROJ'(1) << cur_idx_d : '0;
  end
  assign active_o    = active_q;
  assign cur_idx_o   = cur_idx_q;
  assign cur_valid_o = |active_q;
  assign busy_o      = t_busy;
  assign err_o       = err_q;
`ifdef PROJ_SELECT_ONEHOT_ASSERT_EN
  logic [N_PROJ-1:0] last_q;
  int zero_q;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      last_q <= '0;
      zero_q <= 0;
    end else begin
      assert ($onehot0(active_o));
      assert (cur_valid_o == |active_o);
      if (active_o != '0 && last_q != '0 && active_o != last_q) assert (zero_q >= DEAD_CYCLES);
      cover (last_q == N_PROJ'(1) << (N_PROJ - 2) && active_o == N_PROJ'(1) << (N_PROJ - 1) && zero_q > 0);
      if (active_o != '0) last_q <= active_o;
      zero_q <= active_o == '0 ? zero_q + 1 : 0;
    end
`else
`endif
endmodule

// File: tb/tb_proj_select_ctrl.sv
// tb_proj_select_ctrl: directed and random checks of proj_select_ctrl (N_PROJ=3, DEAD_CYCLES=4) against a cycle model
module tb_proj_select_ctrl;
  localparam int N = 3;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic [1:0] req_idx = '0;
  logic req_off = 1'b0;
  logic req_ready, cur_valid, busy, err;
  logic [N-1:0] active;
  logic [1:0] cur_idx;
  int n_cmp = 0;
  int n_err = 0;
  int m_act, m_dead, m_tgt, m_cidx, m_err;
  always #5 clk = ~clk;
  proj_select_ctrl #(.N_PROJ(N), .DEAD_CYCLES(D)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_idx_i   (req_idx),
    .req_off_i   (req_off),
    .active_o    (active),
    .cur_idx_o   (cur_idx),
    .cur_valid_o (cur_valid),
    .busy_o      (busy),
    .err_o       (err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_act = -1; m_dead = 0; m_tgt = -1; m_cidx = 0; m_err = 0;
  endtask
  task automatic model_edge(input logic v, input int idx, input logic off);
    int e;
    e = 0;
    if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) begin
        m_act = m_tgt;
        if (m_tgt >= 0) m_cidx = m_tgt;
      end
    end else if (v) begin
      if (off) begin
        if (m_act >= 0) begin m_act = -1; m_dead = D; m_tgt = -1; end
      end else if (idx >= N) e = 1;
      else if (idx != m_act) begin m_act = -1; m_dead = D; m_tgt = idx; end
    end
    m_err = e;
  endtask
  task automatic check_all();
    chk("active", 32'(active), m_act < 0 ? 32'd0 : 32'd1 << m_act);
    chk("cur_idx", 32'(cur_idx), 32'(m_cidx));
    chk("cur_valid", 32'(cur_valid), 32'(m_act >= 0));
    chk("busy", 32'(busy), 32'(m_dead > 0));
    chk("ready", 32'(req_ready), 32'(m_dead == 0));
    chk("err", 32'(err), 32'(m_err));
    chk("onehot0", 32'($onehot0(active)), 32'd1);
  endtask
  task automatic step(input logic v, input logic [1:0] idx, input logic off);
    req_valid = v; req_idx = idx; req_off = off;
    @(posedge clk);
    model_edge(v, int'(idx), off);
    #1;
    check_all();
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'd0, 1'b0);
  endtask
  initial begin
    model_reset();
    #2;
    check_all();
    chk("reset_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'd1, 1'b0);
    chk("sel1_busy_c1", 32'(busy), 32'd1);
    idle(3);
    chk("sel1_still_off", 32'(active), 32'd0);
    idle(1);
    chk("sel1_active", 32'(active), 32'b010);
    step(1'b1, 2'd2, 1'b0);
    chk("handover_off", 32'(active), 32'd0);
    idle(4);
    chk("handover_on", 32'(active), 32'b100);
    step(1'b1, 2'd2, 1'b0);
    chk("same_no_busy", 32'(busy), 32'd0);
    chk("same_active", 32'(active), 32'b100);
    step(1'b1, 2'd3, 1'b0);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_cur_idx", 32'(cur_idx), 32'd2);
    step(1'b1, 2'd0, 1'b0);
    chk("bad_err_clear", 32'(err), 32'd0);
    idle(4);
    chk("sel0_active", 32'(active), 32'b001);
    step(1'b1, 2'd2, 1'b1);
    idle(4);
    chk("off_valid", 32'(cur_valid), 32'd0);
    chk("off_ready", 32'(req_ready), 32'd1);
    step(1'b1, 2'd1, 1'b0);
    idle(2);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_active", 32'(active), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(cur_valid), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    for (int k = 0; k < 500; k++)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/proj_select_ctrl.md
Name: proj_select_ctrl

Overview:
- Generalised controller for N wrapped projects sharing one tristate output bus; drives each project's `active` enable.
- Hardware guarantee, not a formal assumption: at most one `active` is high at any time.
- Enforces break-before-make. Every hand-over passes through a programmable all-off dead time, so two drivers never overlap on the shared bus.
- Sits between the Wishbone/logic-analyzer config path and the `active` inputs of the wrapped projects.

Parameters:
- N_PROJ, 2, number of wrapped projects sharing the bus (2..32)
- SEL_W, $clog2(N_PROJ) (min 1), width of the project index
- DEAD_CYCLES, 4, all-off cycles inserted between any deassert and the next assert (1..255)

Ports:
- wb_clk_i  in  1  clock
- wb_rst_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  selection request valid
- req_ready_o  out  1  controller can accept a request this cycle
- req_idx_i  in  SEL_W  requested project index
- req_off_i  in  1  request all-off (req_idx_i ignored)
- active_o  out  N_PROJ  per-project active enables, zero-or-one-hot
- cur_idx_o  out  SEL_W  index of the currently active project
- cur_valid_o  out  1  a project is active (active_o != 0)
- busy_o  out  1  dead-time in progress
- err_o  out  1  one-cycle pulse: request rejected (req_idx_i >= N_PROJ)

Behaviour:
- Reset values: active_o=0, cur_idx_o=0, cur_valid_o=0, busy_o=0, err_o=0, req_ready_o=1, state=OFF. Reset is asynchronous assert, synchronous deassert; the wrapper supplies the synchroniser.
- A handshake occurs when req_valid_i && req_ready_o on a rising edge.
- req_ready_o = (state != DEAD). Requests are never queued; the requester holds req_valid_i until ready.
- States: OFF, DEAD, ON.
- OFF:
  - Valid index accepted -> DEAD; load counter=DEAD_CYCLES; latch pending idx.
  - Off request -> stay OFF; no-op.
- DEAD:
  - active_o=0, busy_o=1.
  - Counter decrements each cycle.
  - Counter reaches 1 -> next cycle ON with active_o[pending]=1, cur_idx_o=pending, cur_valid_o=1.
  - Latency from handshake to active assert is DEAD_CYCLES+1 cycles.
- ON:
  - Different valid index -> active_o cleared on the next edge, enter DEAD with the new pending index.
  - Off request -> clear active_o; enter DEAD with no pending index. At count end go to OFF, not ON. Re-selection is blocked for DEAD_CYCLES.
  - Same index as current -> accepted; no-op; no dead time, no glitch on active_o.
- Invalid index (req_idx_i >= N_PROJ, only possible when N_PROJ is not a power of 2):
  - The request is consumed.
  - err_o pulses high for one cycle.
  - State and outputs are unchanged.
- req_off_i has priority over req_idx_i when both are presented.
- active_o is registered directly from the state/index flops; there is no combinational path from req_* to active_o.
- Reset mid-DEAD or mid-ON: all outputs go to reset values immediately (async); the pending request is lost.
- DEAD_CYCLES=1: exactly one all-off cycle between projects.

Optional Feature:
- Macro: PROJ_SELECT_ONEHOT_ASSERT_EN.
- When defined, the following checks are compiled in, all disabled while wb_rst_n_i=0:
  - Immediate assertion: $onehot0(active_o) every cycle.
  - Assertion: any change of active_o from one nonzero value to a different nonzero value is preceded by at least DEAD_CYCLES consecutive all-zero cycles.
  - Assertion: cur_valid_o == |active_o.
  - Cover: a hand-over between the two highest indices.
- When undefined, no assertion/cover code is present. Functional RTL is identical either way.

Decomposition:
- Package proj_select_pkg:
  - state enum {OFF, DEAD, ON}
  - localparam helpers: SEL_W computation, max DEAD_CYCLES
- One natural sub-module: proj_dead_timer.
  - Loadable down-counter, 8 bits.
  - Ports: load, load_val, busy, done pulse.
- Decoder, FSM and handshake stay in the top module.

Test Plan:
- Reset, then request idx=1 with N_PROJ=4, DEAD_CYCLES=4 -> active_o=4'b0010 on cycle 5 after handshake; busy_o high cycles 1-4; req_ready_o low during busy.
- Active idx=1, request idx=3 -> active_o=0 for exactly 4 cycles, then 4'b1000; never two bits set.
- Active idx=2, request idx=2 -> accepted; active_o unchanged, no all-off cycle; busy_o stays 0.
- N_PROJ=3, request idx=3 -> err_o one-cycle pulse; active_o and cur_idx_o unchanged; next request idx=0 succeeds.
- Active idx=0, request with req_off_i=1 and req_idx_i=2 -> 4 dead cycles, then OFF with cur_valid_o=0; active_o never shows bit 2.
- Assert wb_rst_n_i low mid-DEAD (counter=2) -> active_o, busy_o and cur_valid_o drop asynchronously; after release, req_ready_o=1 and state OFF.
